// File: rtl/regfile_mp_sb_pkg.sv
// Shared types and defaults for the multi-port register file with scoreboard.
package rf_pkg;

    typedef enum logic {RF_CLEAR, RF_RUN} rf_state_e;

    localparam int unsigned RF_XLEN_DEFAULT  = 32;
    localparam int unsigned RF_NREGS_DEFAULT = 32;

endpackage

// File: rtl/regfile_mp_sb_if.sv
// Read/write/scoreboard bus of regfile_mp_sb; master drives requests, slave is the register file.
interface regfile_mp_sb_if
    import rf_pkg::*;
#(
    parameter int unsigned XLEN  = RF_XLEN_DEFAULT,
    parameter int unsigned NREGS = RF_NREGS_DEFAULT,
    parameter int unsigned NRD   = 2,
    parameter int unsigned NWR   = 1
);
    localparam int unsigned AW = $clog2(NREGS);

    logic                ready;
    logic [NWR-1:0]      we;
    logic [NWR*AW-1:0]   wa;
    logic [NWR*XLEN-1:0] wd;
    logic [NRD*AW-1:0]   ra;
    logic [NRD*XLEN-1:0] rd;
    logic [NRD-1:0]      busy;
    logic                sb_set;
    logic [AW-1:0]       sb_addr;

    modport master (
        output we, wa, wd, ra, sb_set, sb_addr,
        input  ready, rd, busy
    );

    modport slave (
        input  we, wa, wd, ra, sb_set, sb_addr,
        output ready, rd, busy
    );

endinterface

// File: rtl/regfile_mp_sb_wr_arbiter.sv
// Combinational write-port match for one address: highest-index enabled port wins.
module rf_wr_arbiter #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned AW   = 5,
    parameter int unsigned NWR  = 1
) (
    input  logic [NWR-1:0]      we,
    input  logic [NWR*AW-1:0]   wa,
    input  logic [NWR*XLEN-1:0] wd,
    input  logic [AW-1:0]       addr,
    output logic                hit,
    output logic [XLEN-1:0]     data
);

    // Ascending scan so a later (higher) port overrides an earlier match; x0 never matches.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int unsigned i = 0; i < NWR; i++) begin
            if (we[i] && (wa[i*AW +: AW] == addr) && (addr != '0)) begin
                hit  = 1'b1;
                data = wd[i*XLEN +: XLEN];
            end
        end
    end

endmodule

// File: rtl/regfile_mp_sb.sv
// Parametrised register file with write-to-read bypass, pending-write scoreboard and post-reset clear sweep.
module regfile_mp_sb
    import rf_pkg::*;
#(
    parameter int unsigned XLEN  = RF_XLEN_DEFAULT,
    parameter int unsigned NREGS = RF_NREGS_DEFAULT,
    parameter int unsigned NRD   = 2,
    parameter int unsigned NWR   = 1
) (
    input logic             clk,
    input logic             rst,
    regfile_mp_sb_if.slave  bus
);
    localparam int unsigned AW = $clog2(NREGS);

    rf_state_e         state;
    logic [AW-1:0]     idx;
    logic [XLEN-1:0]   regs [NREGS];
    logic [NREGS-1:0]  sb;

    logic [NREGS-1:0]  wr_hit;
    logic [XLEN-1:0]   wr_data [NREGS];
    logic [NRD-1:0]    rd_hit;
    logic [XLEN-1:0]   rd_byp  [NRD];

    for (genvar r = 0; r < NREGS; r++) begin : g_wr
        rf_wr_arbiter #(.XLEN(XLEN), .AW(AW), .NWR(NWR)) u_arb (
            .we   (bus.we),
            .wa   (bus.wa),
            .wd   (bus.wd),
            .addr (AW'(r)),
            .hit  (wr_hit[r]),
            .data (wr_data[r])
        );
    end

    for (genvar j = 0; j < NRD; j++) begin : g_rd
        rf_wr_arbiter #(.XLEN(XLEN), .AW(AW), .NWR(NWR)) u_arb (
            .we   (bus.we),
            .wa   (bus.wa),
            .wd   (bus.wd),
            .addr (bus.ra[j*AW +: AW]),
            .hit  (rd_hit[j]),
            .data (rd_byp[j])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RF_CLEAR;
            idx       <= AW'(1);
            bus.ready <= 1'b0;
        end else begin
            case (state)
                RF_CLEAR: begin
                    idx <= idx + AW'(1);
                    if (idx == AW'(NREGS - 1)) begin
                        state     <= RF_RUN;
                        bus.ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= RF_RUN;
                    bus.ready <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs[0] <= '0;
        end else if (state == RF_CLEAR) begin
            regs[idx] <= '0;
        end else begin
            for (int unsigned r = 1; r < NREGS; r++) begin
                if (wr_hit[r]) regs[r] <= wr_data[r];
            end
        end
    end

    // Set takes priority over a same-cycle clear: the new producer is younger than the retiring one.
    always_ff @(posedge clk) begin
        if (rst) begin
            sb <= '0;
        end else if (state == RF_RUN) begin
            for (int unsigned r = 1; r < NREGS; r++) begin
                if (bus.sb_set && (bus.sb_addr == AW'(r))) sb[r] <= 1'b1;
                else if (wr_hit[r])                         sb[r] <= 1'b0;
            end
        end
    end

    always_comb begin
        bus.rd   = '0;
        bus.busy = '0;
        if (state == RF_RUN) begin
            for (int unsigned j = 0; j < NRD; j++) begin
                if (bus.ra[j*AW +: AW] != '0) begin
                    bus.rd[j*XLEN +: XLEN] = rd_hit[j] ? rd_byp[j] : regs[bus.ra[j*AW +: AW]];
                    bus.busy[j]            = sb[bus.ra[j*AW +: AW]] && !rd_hit[j];
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed vector bench for regfile_mp_sb with two write ports and two read ports.
module tb_regfile_mp_sb;
    import rf_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    regfile_mp_sb_if #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2)) bus ();

    regfile_mp_sb #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        sb_set;
        logic [4:0]  sb_addr;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic        b0;
        logic        b1;
    } vec_t;

    vec_t tv [19];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
                         input logic [4:0] wa1, input logic [31:0] wd1,
                         input logic sb_set, input logic [4:0] sb_addr,
                         input logic [4:0] ra0, input logic [4:0] ra1);
        bus.we      = we;
        bus.wa      = {wa1, wa0};
        bus.wd      = {wd1, wd0};
        bus.sb_set  = sb_set;
        bus.sb_addr = sb_addr;
        bus.ra      = {ra1, ra0};
    endtask

    initial begin
        int cyc;

        //         we     wa0  wd0           wa1  wd1          set  sba  ra0 ra1  rd0           rd1           b0 b1
        tv[0]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,       0, 5'd0, 5'd5, 5'd4, 32'h0,        32'h0,        0, 0};
        tv[1]  = '{2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0,       0, 5'd0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0,        0, 0};
        tv[2]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,       0, 5'd0, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0};
        tv[3]  = '{2'b01, 5'd0, 32'h1234,     5'd0, 32'h0,       0, 5'd0, 5'd0, 5'd5, 32'h0,        32'hDEADBEEF, 0, 0};
        tv[4]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,       0, 5'd0, 5'd0, 5'd5, 32'h0,        32'hDEADBEEF, 0, 0};
        tv[5]  = '{2'b11, 5'd7, 32'hAAAA,     5'd7, 32'h5555,    0, 5'd0, 5'd7, 5'd5, 32'h5555,     32'hDEADBEEF, 0, 0};
        tv[6]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,       0, 5'd0, 5'd7, 5'd7, 32'h5555,     32'h5555,     0, 0};
        tv[7]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,       1, 5'd3, 5'd3, 5'd7, 32'h0,        32'h5555,     0, 0};
        tv[8]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,       0, 5'd0, 5'd3, 5'd3, 32'h0,        32'h0,        1, 1};
        tv[9]  = '{2'b01, 5'd3, 32'h42,       5'd0, 32'h0,       0, 5'd0, 5'd3, 5'd5, 32'h42,       32'hDEADBEEF, 0, 0};
        tv[10] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,       0, 5'd0, 5'd3, 5'd3, 32'h42,       32'h42,       0, 0};
        tv[11] = '{2'b10, 5'd0, 32'h0,        5'd9, 32'h9999,    1, 5'd9, 5'd9, 5'd0, 32'h9999,     32'h0,        0, 0};
        tv[12] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,       0, 5'd0, 5'd9, 5'd9, 32'h9999,     32'h9999,     1, 1};
        tv[13] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,       1, 5'd0, 5'd0, 5'd9, 32'h0,        32'h9999,     0, 1};
        tv[14] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,       0, 5'd0, 5'd0, 5'd9, 32'h0,        32'h9999,     0, 1};
        tv[15] = '{2'b11, 5'd10, 32'h10,      5'd11, 32'h11,     0, 5'd0, 5'd10, 5'd11, 32'h10,     32'h11,       0, 0};
        tv[16] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,       0, 5'd0, 5'd10, 5'd11, 32'h10,     32'h11,       0, 0};
        tv[17] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,       1, 5'd3, 5'd3, 5'd5, 32'h42,       32'hDEADBEEF, 0, 0};
        tv[18] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,       0, 5'd0, 5'd3, 5'd5, 32'h42,       32'hDEADBEEF, 1, 0};

        // Reset for two edges, then run the sweep with writes and a scoreboard set that must be ignored.
        drive(2'b01, 5'd5, 32'hFFFF, 5'd0, 32'h0, 1'b1, 5'd4, 5'd5, 5'd4);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int c = 1; c <= 31; c++) begin
            check($sformatf("sweep_ready_c%0d", c), {31'b0, bus.ready}, 32'h0);
            if (c == 1 || c == 16 || c == 31) begin
                check("sweep_rd0", bus.rd[31:0], 32'h0);
                check("sweep_busy", {30'b0, bus.busy}, 32'h0);
            end
            tick();
        end
        check("sweep_ready_done", {31'b0, bus.ready}, 32'h1);

        for (int i = 0; i < 19; i++) begin
            drive(tv[i].we, tv[i].wa0, tv[i].wd0, tv[i].wa1, tv[i].wd1,
                  tv[i].sb_set, tv[i].sb_addr, tv[i].ra0, tv[i].ra1);
            #1;
            check($sformatf("v%0d_rd0", i), bus.rd[31:0], tv[i].rd0);
            check($sformatf("v%0d_rd1", i), bus.rd[63:32], tv[i].rd1);
            check($sformatf("v%0d_busy", i), {30'b0, bus.busy}, {30'b0, tv[i].b1, tv[i].b0});
            tick();
        end

        // Reset from RUN, then reset again ten cycles into the sweep; sweep must restart fully.
        drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_ready_low", {31'b0, bus.ready}, 32'h0);
        check("rst_busy_clear", {30'b0, bus.busy}, 32'h0);
        check("rst_rd1_zero", bus.rd[63:32], 32'h0);
        for (int c = 0; c < 10; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cyc = 0;
        while (!bus.ready && cyc < 40) begin
            tick();
            cyc++;
        end
        check("restart_sweep_len", cyc, 32'd31);
        #1;
        check("post_rst_x5", bus.rd[63:32], 32'h0);
        check("post_rst_x3", bus.rd[31:0], 32'h0);
        check("post_rst_busy", {30'b0, bus.busy}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
